// File: rtl/ets_sweep_core.sv
// ets_sweep_core: equivalent-time-sampling sweep engine.
// Steps the MMCM phase through num_steps positions. At each position it waits for a trigger
// rising edge and sums each 1-bit probe over `average` cycles. The per-channel sums are then
// streamed out, and the phase can optionally be rewound to origin when the sweep ends.
module ets_sweep_core #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned ACC_W      = 32,
  parameter int unsigned STEP_W     = 10,
  parameter int unsigned PS_TIMEOUT = 1023
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_en,
  input  logic                    i_abort,
  input  logic [ACC_W-1:0]        i_average,
  input  logic [STEP_W-1:0]       i_num_steps,
  input  logic                    i_cont_mode,
  input  logic                    i_rewind,
  input  logic [NUM_CH-1:0]       i_data_in,
  input  logic                    i_trigger,
  output logic [NUM_CH*ACC_W-1:0] o_m_data,
  output logic [STEP_W-1:0]       o_m_step,
  output logic                    o_m_last,
  output logic                    o_m_valid,
  input  logic                    i_m_ready,
  output logic                    o_ps_en,
  output logic                    o_ps_incdec,
  output logic                    o_ps_clk,
  input  logic                    i_ps_done,
  output logic                    o_busy,
  output logic                    o_ps_err
);

  localparam int unsigned OFF_W = STEP_W + 1;
  localparam int unsigned TMR_W = $clog2(PS_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StAccum,
    StOutput,
    StPsReq,
    StPsWait,
    StRwReq,
    StRwWait
  } state_e;

  state_e                         r_state;
  state_e                         w_state_next;

  // Sweep configuration, frozen for the duration of a sweep
  logic [ACC_W-1:0]               r_avg;
  logic [STEP_W-1:0]              r_nsteps;
  logic                           r_cont;
  logic                           r_rewind;

  logic                           r_trig_q;
  logic                           r_en_q;
  logic [STEP_W-1:0]              r_step;
  logic [OFF_W-1:0]               r_offset;
  logic [ACC_W-1:0]               r_cnt;
  logic [TMR_W-1:0]               r_timer;
  logic [NUM_CH-1:0][ACC_W-1:0]   r_acc;
  logic                           r_abort_pend;
  logic                           r_ps_err;

  logic                           w_edge;
  logic                           w_abort_any;
  logic                           w_last_step;
  logic                           w_rw_ok;
  logic                           w_avg_done;
  logic                           w_single;
  logic                           w_timeout;
  logic                           w_ps_timeout;
  logic                           w_restart;
  state_e                         w_abort_dest;

  assign w_edge       = i_trigger & ~r_trig_q;
  assign w_abort_any  = i_abort | r_abort_pend;
  assign w_last_step  = (r_step == (r_nsteps - STEP_W'(1)));
  assign w_rw_ok      = r_rewind && (r_offset != '0);
  assign w_avg_done   = (r_cnt == (r_avg - ACC_W'(1)));
  assign w_single     = (r_avg == ACC_W'(1));
  assign w_timeout    = (r_timer == TMR_W'(PS_TIMEOUT - 1));
  assign w_ps_timeout = ((r_state == StPsWait) || (r_state == StRwWait)) && !i_ps_done &&
                        w_timeout;
  // Abort from a capture state unwinds the phase only if it has moved
  assign w_abort_dest = w_rw_ok ? StRwReq : StIdle;
  // Continuous-mode restart begins a fresh sweep at step 0
  assign w_restart    = (w_state_next == StArm) &&
                        ((r_state == StOutput) || (r_state == StRwWait));

  assign o_m_data = r_acc;
  assign o_m_step = r_step;
  assign o_ps_clk = i_clk;
  assign o_ps_err = r_ps_err;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (i_en) w_state_next = StArm;
      end
      StArm: begin
        if (i_abort) begin
          w_state_next = w_abort_dest;
        end else if (w_edge) begin
          // The edge cycle is sample 0, so a one-sample average is already complete
          w_state_next = w_single ? StOutput : StAccum;
        end
      end
      StAccum: begin
        if (i_abort) begin
          w_state_next = w_abort_dest;
        end else if (w_avg_done) begin
          w_state_next = StOutput;
        end
      end
      StOutput: begin
        if (i_abort) begin
          w_state_next = w_abort_dest;
        end else if (i_m_ready) begin
          if (!w_last_step) begin
            w_state_next = StPsReq;
          end else if (w_rw_ok) begin
            w_state_next = StRwReq;
          end else if (r_cont) begin
            w_state_next = StArm;
          end else begin
            w_state_next = StIdle;
          end
        end
      end
      StPsReq: begin
        w_state_next = StPsWait;
      end
      StPsWait: begin
        if (i_ps_done) begin
          // Offset is nonzero after this increment, so rewind always has work to do
          if (w_abort_any) begin
            w_state_next = r_rewind ? StRwReq : StIdle;
          end else begin
            w_state_next = StArm;
          end
        end else if (w_timeout) begin
          w_state_next = StIdle;
        end
      end
      StRwReq: begin
        w_state_next = StRwWait;
      end
      StRwWait: begin
        if (i_ps_done) begin
          if (r_offset == OFF_W'(1)) begin
            w_state_next = (r_cont && !w_abort_any) ? StArm : StIdle;
          end else begin
            w_state_next = StRwReq;
          end
        end else if (w_timeout) begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Output decode from current state
  always_comb begin
    o_m_valid   = 1'b0;
    o_m_last    = 1'b0;
    o_ps_en     = 1'b0;
    o_ps_incdec = 1'b0;
    o_busy      = (r_state != StIdle);
    case (r_state)
      StOutput: begin
        o_m_valid = 1'b1;
        o_m_last  = w_last_step;
      end
      StPsReq: begin
        o_ps_en     = 1'b1;
        o_ps_incdec = 1'b1;
      end
      StRwReq: begin
        o_ps_en = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Datapath: configuration latch, accumulators, step/offset counters, timeout and error flag
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_avg        <= '0;
      r_nsteps     <= '0;
      r_cont       <= 1'b0;
      r_rewind     <= 1'b0;
      r_trig_q     <= 1'b0;
      r_en_q       <= 1'b0;
      r_step       <= '0;
      r_offset     <= '0;
      r_cnt        <= '0;
      r_timer      <= '0;
      r_acc        <= '0;
      r_abort_pend <= 1'b0;
      r_ps_err     <= 1'b0;
    end else begin
      r_trig_q <= i_trigger;
      r_en_q   <= i_en;

      if (w_ps_timeout) begin
        r_ps_err <= 1'b1;
      end else if (i_en && !r_en_q) begin
        r_ps_err <= 1'b0;
      end

      if ((r_state == StPsWait) || (r_state == StRwWait)) begin
        r_timer <= r_timer + TMR_W'(1);
      end else begin
        r_timer <= '0;
      end

      // Remember an abort so a shift in flight can finish before it takes effect
      if (i_abort && (r_state != StIdle)) begin
        r_abort_pend <= 1'b1;
      end

      case (r_state)
        StIdle: begin
          if (i_en) begin
            r_avg        <= (i_average == '0) ? ACC_W'(1) : i_average;
            r_nsteps     <= (i_num_steps == '0) ? STEP_W'(1) : i_num_steps;
            r_cont       <= i_cont_mode;
            r_rewind     <= i_rewind;
            r_step       <= '0;
            r_offset     <= '0;
            r_abort_pend <= 1'b0;
          end
        end
        StArm: begin
          r_cnt <= ACC_W'(1);
          for (int unsigned c = 0; c < NUM_CH; c++) begin
            r_acc[c] <= w_edge ? ACC_W'(i_data_in[c]) : '0;
          end
        end
        StAccum: begin
          r_cnt <= r_cnt + ACC_W'(1);
          for (int unsigned c = 0; c < NUM_CH; c++) begin
            r_acc[c] <= r_acc[c] + ACC_W'(i_data_in[c]);
          end
        end
        StPsWait: begin
          if (i_ps_done) begin
            r_offset <= r_offset + OFF_W'(1);
            r_step   <= r_step + STEP_W'(1);
          end
        end
        StRwWait: begin
          if (i_ps_done) begin
            r_offset <= r_offset - OFF_W'(1);
          end
        end
        default: begin
        end
      endcase

      if (w_restart) begin
        r_step <= '0;
      end
    end
  end

endmodule
